// File: rtl/exu_lsu_pkg.sv
// Shared definitions for the load/store unit: bus widths, RV32I width codes and
// the byte-lane helpers used on the store and address-check paths.
package exu_lsu_pkg;

    localparam int unsigned ADDR_LEN = 32;
    localparam int unsigned WORD_LEN = 32;

    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;
    localparam logic [2:0] Funct3Sb  = 3'b000;
    localparam logic [2:0] Funct3Sh  = 3'b001;
    localparam logic [2:0] Funct3Sw  = 3'b010;

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] offset);
        case (funct3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(logic [2:0] funct3, logic [1:0] offset);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << offset;
            2'b01:   return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [WORD_LEN-1:0] store_data(logic [2:0] funct3,
                                                       logic [WORD_LEN-1:0] wdata);
        case (funct3)
            Funct3Sb: return {4{wdata[7:0]}};
            Funct3Sh: return {2{wdata[15:0]}};
            default:  return wdata;
        endcase
    endfunction

endpackage

// File: rtl/exu_lsu_align.sv
// Load lane extraction: picks the addressed byte/half out of the bus word and
// sign- or zero-extends it according to the load width code.
module lsu_align
    import exu_lsu_pkg::*;
(
    input  logic [2:0]          funct3,
    input  logic [1:0]          offset,
    input  logic [WORD_LEN-1:0] rdata,
    output logic [WORD_LEN-1:0] data
);

    logic [WORD_LEN-1:0] lane;

    always_comb begin
        lane = rdata >> {offset, 3'b000};
        case (funct3)
            Funct3Lb:  data = {{(WORD_LEN-8){lane[7]}}, lane[7:0]};
            Funct3Lbu: data = {{(WORD_LEN-8){1'b0}}, lane[7:0]};
            Funct3Lh:  data = {{(WORD_LEN-16){lane[15]}}, lane[15:0]};
            Funct3Lhu: data = {{(WORD_LEN-16){1'b0}}, lane[15:0]};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/exu_lsu.sv
// Load/store unit: accepts one request from the ALU stage, runs a single bus
// transaction with timeout, and returns load data to the register file.
module exu_lsu
    import exu_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    input  logic                req_we_i,
    input  logic [2:0]          req_funct3_i,
    input  logic [ADDR_LEN-1:0] req_addr_i,
    input  logic [WORD_LEN-1:0] req_wdata_i,
    input  logic [4:0]          req_rd_i,
    output logic                wait_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [ADDR_LEN-1:0] bus_addr_o,
    output logic [WORD_LEN-1:0] bus_wdata_o,
    output logic [3:0]          bus_be_o,
    input  logic                bus_ack_i,
    input  logic [WORD_LEN-1:0] bus_rdata_i,
    output logic                wb_valid_o,
    output logic [4:0]          wb_addr_o,
    output logic [WORD_LEN-1:0] wb_data_o,
    output logic                err_misalign_o,
    output logic                err_bus_o
);

    typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [2:0]          funct3_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [WORD_LEN-1:0] wdata_q;
    logic [WORD_LEN-1:0] rdata_q;
    logic [4:0]          rd_q;
    logic                bus_err_q;

    logic                accept;
    logic                in_req;
    logic                timeout_hit;
    logic [WORD_LEN-1:0] load_data;

    assign accept      = (state_q == StIdle) && req_valid_i;
    assign in_req      = (state_q == StReq);
    assign timeout_hit = (cnt_q + 8'd1) == TimeoutCnt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                if (accept) begin
                    state_d = is_misaligned(req_funct3_i, req_addr_i[1:0]) ? StErr : StReq;
                end
            end
            StReq: begin
                if (bus_ack_i) begin
                    state_d = StDone;
                    cnt_d   = 8'd0;
                end else if (timeout_hit) begin
                    state_d = StErr;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rd_q      <= 5'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q      <= req_we_i;
                funct3_q  <= req_funct3_i;
                addr_q    <= req_addr_i;
                wdata_q   <= req_wdata_i;
                rd_q      <= req_rd_i;
                bus_err_q <= 1'b0;
            end
            if (in_req && bus_ack_i) begin
                rdata_q <= bus_rdata_i;
            end
            if (in_req && !bus_ack_i && timeout_hit) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    lsu_align u_align (
        .funct3 (funct3_q),
        .offset (addr_q[1:0]),
        .rdata  (rdata_q),
        .data   (load_data)
    );

    // Bus and write-back outputs are zeroed outside their active state.
    always_comb begin
        wait_o         = !rst && (accept || in_req);
        bus_req_o      = in_req;
        bus_we_o       = in_req && we_q;
        bus_addr_o     = in_req ? {addr_q[ADDR_LEN-1:2], 2'b00} : '0;
        bus_be_o       = in_req ? byte_enable(funct3_q, addr_q[1:0]) : 4'b0000;
        bus_wdata_o    = in_req ? store_data(funct3_q, wdata_q) : '0;
        wb_valid_o     = (state_q == StDone) && !we_q && (rd_q != 5'd0);
        wb_addr_o      = wb_valid_o ? rd_q : 5'd0;
        wb_data_o      = wb_valid_o ? load_data : '0;
        err_misalign_o = (state_q == StErr) && !bus_err_q;
        err_bus_o      = (state_q == StErr) && bus_err_q;
    end

endmodule

// File: tb/tb_exu_lsu.sv
// Directed bench for exu_lsu: every cycle is checked against expectations derived
// from byte-lane arithmetic, plus literal per-transaction totals.
module tb_exu_lsu;

    localparam int unsigned TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [4:0]  req_rd = 5'd0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    logic        wait_o, bus_req_o, bus_we_o, wb_valid_o, err_misalign_o, err_bus_o;
    logic [31:0] bus_addr_o, bus_wdata_o, wb_data_o;
    logic [3:0]  bus_be_o;
    logic [4:0]  wb_addr_o;

    exu_lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_we_i       (req_we),
        .req_funct3_i   (req_funct3),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_rd_i       (req_rd),
        .wait_o         (wait_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_be_o       (bus_be_o),
        .bus_ack_i      (bus_ack),
        .bus_rdata_i    (bus_rdata),
        .wb_valid_o     (wb_valid_o),
        .wb_addr_o      (wb_addr_o),
        .wb_data_o      (wb_data_o),
        .err_misalign_o (err_misalign_o),
        .err_bus_o      (err_bus_o)
    );

    always #5 clk = ~clk;

    // Per-cycle expectations, written by the stimulus, read by the compare process.
    logic        e_wait, e_req, e_we, e_wbv, e_em, e_eb;
    logic [31:0] e_addr, e_wdata, e_wbd;
    logic [3:0]  e_be;
    logic [4:0]  e_wba;
    logic        check_en = 1'b0;
    logic        txn_start = 1'b0;
    logic        lit_valid = 1'b0;
    int          lit_nreq, lit_nwb, lit_nem, lit_neb;
    logic [3:0]  lit_be;
    logic [31:0] lit_addr, lit_wbd;
    logic [4:0]  lit_wba;

    int          n_checks = 0;
    int          n_fail = 0;
    int          m_req, m_wb, m_em, m_eb;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wbd;
    logic [4:0]  m_wba;

    function automatic int unsigned nbytes(logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic model_misaligned(logic [2:0] f3, logic [31:0] addr);
        return (addr % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(logic [2:0] f3, logic [31:0] addr);
        int unsigned n = nbytes(f3);
        int unsigned off = addr % 4;
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] wdata);
        longint w = longint'(wdata);
        if (nbytes(f3) == 1) return 32'((w % 256) * 32'h0101_0101);
        if (nbytes(f3) == 2) return 32'((w % 65536) * 32'h0001_0001);
        return wdata;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] addr,
                                               logic [31:0] rdata);
        longint one = 1;
        int unsigned bits = 8 * nbytes(f3);
        int unsigned off = addr % 4;
        longint v = (longint'(rdata) >> (8 * off)) % (one << bits);
        if (!f3[2] && bits < 32 && v >= (one << (bits - 1))) v = v - (one << bits);
        return 32'(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT outputs against the expectations on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (txn_start) begin
                m_req = 0; m_wb = 0; m_em = 0; m_eb = 0;
                m_be = 4'h0; m_addr = 32'h0; m_wbd = 32'h0; m_wba = 5'd0;
            end
            if (bus_req_o) begin m_req++; m_be = bus_be_o; m_addr = bus_addr_o; end
            if (wb_valid_o) begin m_wb++; m_wbd = wb_data_o; m_wba = wb_addr_o; end
            if (err_misalign_o) m_em++;
            if (err_bus_o) m_eb++;
            if (check_en) begin
                chk("wait_o", 32'(wait_o), 32'(e_wait));
                chk("bus_req_o", 32'(bus_req_o), 32'(e_req));
                chk("bus_we_o", 32'(bus_we_o), 32'(e_we));
                chk("bus_addr_o", bus_addr_o, e_addr);
                chk("bus_be_o", 32'(bus_be_o), 32'(e_be));
                if (e_we) chk("bus_wdata_o", bus_wdata_o, e_wdata);
                chk("wb_valid_o", 32'(wb_valid_o), 32'(e_wbv));
                chk("wb_addr_o", 32'(wb_addr_o), 32'(e_wba));
                chk("wb_data_o", wb_data_o, e_wbd);
                chk("err_misalign_o", 32'(err_misalign_o), 32'(e_em));
                chk("err_bus_o", 32'(err_bus_o), 32'(e_eb));
            end
            if (lit_valid) begin
                chk("txn_req_cycles", 32'(m_req), 32'(lit_nreq));
                chk("txn_wb_pulses", 32'(m_wb), 32'(lit_nwb));
                chk("txn_misalign_pulses", 32'(m_em), 32'(lit_nem));
                chk("txn_bus_err_pulses", 32'(m_eb), 32'(lit_neb));
                chk("txn_be", 32'(m_be), 32'(lit_be));
                chk("txn_addr", m_addr, lit_addr);
                chk("txn_wb_data", m_wbd, lit_wbd);
                chk("txn_wb_addr", 32'(m_wba), 32'(lit_wba));
            end
        end
    end

    task automatic clear_exp();
        e_wait = 0; e_req = 0; e_we = 0; e_wbv = 0; e_em = 0; e_eb = 0;
        e_addr = 32'h0; e_wdata = 32'h0; e_wbd = 32'h0; e_be = 4'h0; e_wba = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ack_delay < 0 means the bus never answers.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd,
                           input int ack_delay, input logic [31:0] rdata);
        int n;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr;
        req_wdata = wdata; req_rd = rd; bus_ack = 0; bus_rdata = 32'h0;
        txn_start = 1;
        clear_exp(); e_wait = 1;
        tick();
        txn_start = 0;
        if (model_misaligned(f3, addr)) begin
            req_valid = 0;
            clear_exp(); e_em = 1;
            tick();
            clear_exp();
            return;
        end
        // The request is held but must be ignored; scramble it to prove latching.
        req_we = ~we; req_funct3 = ~f3; req_addr = ~addr; req_wdata = ~wdata; req_rd = ~rd;
        n = (ack_delay < 0) ? int'(TIMEOUT) : ack_delay + 1;
        for (int k = 0; k < n; k++) begin
            bus_ack = (k == ack_delay);
            bus_rdata = (k == ack_delay) ? rdata : 32'h5A5A_A5A5;
            clear_exp();
            e_wait = 1; e_req = 1; e_we = we;
            e_addr = addr - (addr % 4);
            e_be = model_be(f3, addr);
            e_wdata = model_wdata(f3, wdata);
            tick();
        end
        req_valid = 0;
        bus_ack = 1; bus_rdata = 32'hC3C3_3C3C;
        clear_exp();
        if (ack_delay < 0) begin
            e_eb = 1;
        end else if (!we && rd != 5'd0) begin
            e_wbv = 1; e_wba = rd; e_wbd = model_load(f3, addr, rdata);
        end
        tick();
        bus_ack = 0;
        clear_exp();
    endtask

    task automatic check_txn(input int nreq, input int nwb, input int nem, input int neb,
                             input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wbd, input logic [4:0] wba);
        lit_nreq = nreq; lit_nwb = nwb; lit_nem = nem; lit_neb = neb;
        lit_be = be; lit_addr = addr; lit_wbd = wbd; lit_wba = wba;
        lit_valid = 1;
        tick();
        lit_valid = 0;
    endtask

    initial begin
        clear_exp();
        check_en = 1;
        req_valid = 1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 0; req_valid = 0;
        tick();

        run_txn(1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0, 0, 32'h0);
        check_txn(1, 0, 0, 0, 4'b1111, 32'h100, 32'h0, 5'd0);
        run_txn(0, 3'b000, 32'h103, 32'h0, 5'd5, 0, 32'h80FF_FF7F);
        check_txn(1, 1, 0, 0, 4'b1000, 32'h100, 32'hFFFF_FF80, 5'd5);
        run_txn(0, 3'b101, 32'h102, 32'h0, 5'd7, 0, 32'h8001_0000);
        check_txn(1, 1, 0, 0, 4'b1100, 32'h100, 32'h0000_8001, 5'd7);
        run_txn(0, 3'b001, 32'h101, 32'h0, 5'd8, 0, 32'h0);
        check_txn(0, 0, 1, 0, 4'b0000, 32'h0, 32'h0, 5'd0);
        run_txn(0, 3'b010, 32'h204, 32'h0, 5'd9, 3, 32'h1234_5678);
        check_txn(4, 1, 0, 0, 4'b1111, 32'h204, 32'h1234_5678, 5'd9);
        run_txn(0, 3'b010, 32'h300, 32'h0, 5'd3, -1, 32'h0);
        check_txn(255, 0, 0, 1, 4'b1111, 32'h300, 32'h0, 5'd0);
        run_txn(0, 3'b010, 32'h304, 32'h0, 5'd4, 0, 32'hCAFE_F00D);
        check_txn(1, 1, 0, 0, 4'b1111, 32'h304, 32'hCAFE_F00D, 5'd4);
        run_txn(1, 3'b000, 32'h102, 32'h0000_00A5, 5'd1, 1, 32'h0);
        check_txn(2, 0, 0, 0, 4'b0100, 32'h100, 32'h0, 5'd0);
        run_txn(1, 3'b001, 32'h206, 32'h1234_BEEF, 5'd1, 0, 32'h0);
        check_txn(1, 0, 0, 0, 4'b1100, 32'h204, 32'h0, 5'd0);
        run_txn(0, 3'b000, 32'h101, 32'h0, 5'd10, 0, 32'h0000_7F00);
        check_txn(1, 1, 0, 0, 4'b0010, 32'h100, 32'h0000_007F, 5'd10);
        run_txn(0, 3'b001, 32'h102, 32'h0, 5'd11, 2, 32'hFFFE_0000);
        check_txn(3, 1, 0, 0, 4'b1100, 32'h100, 32'hFFFF_FFFE, 5'd11);
        run_txn(0, 3'b100, 32'h100, 32'h0, 5'd12, 0, 32'h0000_00FF);
        check_txn(1, 1, 0, 0, 4'b0001, 32'h100, 32'h0000_00FF, 5'd12);
        run_txn(0, 3'b010, 32'h108, 32'h0, 5'd0, 0, 32'h1111_1111);
        check_txn(1, 0, 0, 0, 4'b1111, 32'h108, 32'h0, 5'd0);
        run_txn(1, 3'b010, 32'h102, 32'h5555_5555, 5'd0, 0, 32'h0);
        check_txn(0, 0, 1, 0, 4'b0000, 32'h0, 32'h0, 5'd0);
        run_txn(0, 3'b101, 32'h103, 32'h0, 5'd2, 0, 32'h0);
        check_txn(0, 0, 1, 0, 4'b0000, 32'h0, 32'h0, 5'd0);
        run_txn(1, 3'b001, 32'h101, 32'h0000_1234, 5'd0, 0, 32'h0);
        check_txn(0, 0, 1, 0, 4'b0000, 32'h0, 32'h0, 5'd0);
        run_txn(1, 3'b000, 32'h203, 32'hAAAA_AA77, 5'd0, 0, 32'h0);
        check_txn(1, 0, 0, 0, 4'b1000, 32'h200, 32'h0, 5'd0);

        // Reset in the middle of a bus access, then stray acks while idle.
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h400;
        req_wdata = 32'h0; req_rd = 5'd6; bus_ack = 0;
        txn_start = 1;
        clear_exp(); e_wait = 1;
        tick();
        txn_start = 0;
        clear_exp(); e_wait = 1; e_req = 1; e_addr = 32'h400; e_be = 4'b1111;
        tick();
        clear_exp();
        #1 rst = 1;
        tick();
        rst = 0; req_valid = 0; bus_ack = 1; bus_rdata = 32'h7777_7777;
        repeat (3) tick();
        bus_ack = 0;
        check_txn(1, 0, 0, 0, 4'b1111, 32'h400, 32'h0, 5'd0);

        run_txn(0, 3'b000, 32'h102, 32'h0, 5'd13, 0, 32'h0080_0000);
        check_txn(1, 1, 0, 0, 4'b0100, 32'h100, 32'hFFFF_FF80, 5'd13);

        tick();
        check_en = 0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exu_lsu.md
EXU_LSU -- requirements
Module: exu_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning maximum wait cycles for bus_ack before a bus error is flagged.
REQ-002 SHALL have ports `clk` (input, 1, sole clock) and `rst` (input, 1, asynchronous active-high reset).
REQ-003 SHALL have `req_valid_i` (in, 1): load/store request from the ALU stage.
REQ-004 SHALL have `req_we_i` (in, 1): 1 = store, 0 = load.
REQ-005 SHALL have `req_funct3_i` (in, 3): RV32I width code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-006 SHALL have `req_addr_i` (in, `ADDR_LEN`): byte address.
REQ-007 SHALL have `req_wdata_i` (in, `WORD_LEN`): store data, right-aligned.
REQ-008 SHALL have `req_rd_i` (in, 5): load destination register.
REQ-009 SHALL have `wait_o` (out, 1): stall request to ctrl.
REQ-010 SHALL have `bus_req_o` (out, 1), `bus_we_o` (out, 1), `bus_addr_o` (out, `ADDR_LEN`, word-aligned), `bus_wdata_o` (out, `WORD_LEN`) and `bus_be_o` (out, 4): memory request channel.
REQ-011 SHALL have `bus_ack_i` (in, 1) and `bus_rdata_i` (in, `WORD_LEN`): memory response channel.
REQ-012 SHALL have `wb_valid_o` (out, 1), `wb_addr_o` (out, 5) and `wb_data_o` (out, `WORD_LEN`): register write-back.
REQ-013 SHALL have `err_misalign_o` (out, 1) and `err_bus_o` (out, 1): one-cycle exception pulses.

Function
REQ-014 SHALL implement FSM IDLE -> REQ -> DONE -> IDLE, plus IDLE -> ERR -> IDLE.
REQ-015 IDLE: when req_valid_i=1, SHALL latch all req_* inputs; misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) -> ERR, otherwise -> REQ.
REQ-016 REQ: SHALL hold bus_req_o=1 and all bus_* outputs stable until bus_ack_i=1, then -> DONE, capturing bus_rdata_i.
REQ-017 bus_addr_o SHALL equal {addr[31:2],2'b00}.
REQ-018 bus_be_o SHALL be: byte access 4'b0001<<addr[1:0]; half access 4'b0011<<addr[1:0]; word access 4'b1111; value is identical for loads and stores.
REQ-019 bus_wdata_o SHALL replicate the store byte 4x (SB), the store half 2x (SH), or pass the word through (SW).
REQ-020 Loads SHALL select the lane by addr[1:0]; LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, LW SHALL pass through.
REQ-021 DONE: for loads, SHALL drive wb_valid_o=1 for exactly one cycle with wb_addr_o=rd and wb_data_o=extended data; for stores wb_valid_o SHALL stay 0; -> IDLE.
REQ-022 Load with rd=0 SHALL complete the bus access but keep wb_valid_o=0.
REQ-023 In REQ, an 8-bit wait counter SHALL increment each cycle without ack; on reaching TIMEOUT, SHALL drop bus_req_o and go -> ERR with err_bus_o.
REQ-024 ERR: SHALL pulse the applicable err_* output for one cycle, perform no bus access and no write-back, then -> IDLE.
REQ-025 wait_o SHALL be 1 combinationally when req_valid_i=1 in IDLE, and 1 throughout REQ; it SHALL be 0 in DONE, ERR, and idle-without-request.
REQ-026 bus_ack_i outside REQ SHALL be ignored.
REQ-027 req_valid_i outside IDLE SHALL be ignored; ctrl holds the request while wait_o=1.
REQ-028 Best-case load latency SHALL be: accept in cycle 0, bus_req_o in cycle 1, ack in cycle 1, wb_valid_o in cycle 2.

Reset
REQ-029 rst=1 SHALL force state IDLE, wait counter to 0 and all outputs to 0, including bus_req_o, wait_o, wb_valid_o, err_*, bus_be_o and data/address outputs.
REQ-030 Reset asserted mid-REQ SHALL drop bus_req_o immediately (asynchronously), and no write-back SHALL follow.

Structure
REQ-031 funct3 width codes and `ADDR_LEN`/`WORD_LEN` SHALL come from core.h.
REQ-032 State encodings SHALL be local to the module.
REQ-033 Lane extraction and extension SHALL live in one combinational sub-module, lsu_align.

Verification
REQ-034 SW x=0xDEADBEEF to 0x100, ack same cycle -> bus_be=1111, bus_addr=0x100, no wb, wait_o low in cycle 2.
REQ-035 LB from 0x103 with rdata=0x80FF_FF7F, rd=5 -> be=1000, wb_data=0xFFFFFF80, wb_addr=5, one-cycle wb_valid.
REQ-036 LHU from 0x102 with rdata=0x8001_0000 -> wb_data=0x00008001; LH from 0x101 -> err_misalign pulse, bus_req never asserted.
REQ-037 LW with ack delayed 3 cycles -> bus_req held 4 cycles with stable address, wait_o high throughout, single wb_valid.
REQ-038 LW with no ack, TIMEOUT=255 -> err_bus pulses after 255 REQ cycles, FSM returns to IDLE, next request serviced normally.
REQ-039 rst asserted during REQ -> bus_req_o=0 the same cycle, no wb_valid afterwards; spurious bus_ack while IDLE -> no effect.
